// File: rtl/dma_bus_arbiter.sv
// Two-master (CPU, DMA) arbiter for a single-port memory with CPU priority
// and a bounded DMA starvation counter; each access takes IDLE->ACCESS->ACK.
module dma_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [7:0]  dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  bus_owner
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       dma_wins;

   // DMA wins when alone, or when it has lost LIMIT contested rounds in a row.
   always_comb begin
      dma_wins = dma_req && (!cpu_req || (starve_cnt == LIMIT));
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
         bus_owner  <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  state  <= ACCESS;
                  mem_en <= 1'b1;
                  if (dma_wins) begin
                     mem_we     <= dma_we;
                     mem_addr   <= dma_addr;
                     mem_wdata  <= dma_wdata;
                     bus_owner  <= OWN_DMA;
                     starve_cnt <= '0;
                  end else begin
                     mem_we    <= cpu_we;
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                     bus_owner <= OWN_CPU;
                     if (dma_req && (starve_cnt != LIMIT))
                        starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            ACCESS: begin
               state  <= ACK;
               mem_en <= 1'b0;
               if (bus_owner == OWN_DMA) begin
                  dma_ack <= 1'b1;
                  if (!mem_we) dma_rdata <= mem_rdata;
               end else begin
                  cpu_ack <= 1'b1;
                  if (!mem_we) cpu_rdata <= mem_rdata;
               end
            end
            ACK: begin
               state     <= IDLE;
               cpu_ack   <= 1'b0;
               dma_ack   <= 1'b0;
               bus_owner <= OWN_NONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a per-cycle vector table followed by
// hand-written starvation, reset-abort and withdrawn-request sequences.
module tb_dma_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [7:0]  cpu_addr, dma_addr;
   logic [31:0] cpu_wdata, dma_wdata, mem_rdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
   logic        cpu_ack, dma_ack, mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [1:0]  bus_owner;

   int checks = 0;
   int errors = 0;
   int mutex_viol = 0;

   always #5 clk = ~clk;

   dma_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .bus_owner(bus_owner)
   );

   typedef struct {
      logic        rst;
      logic        creq, cwe;
      logic [7:0]  caddr;
      logic [31:0] cwd;
      logic        dreq, dwe;
      logic [7:0]  daddr;
      logic [31:0] dwd;
      logic [31:0] mrd;
      logic        e_men, e_mwe;
      logic [7:0]  e_maddr;
      logic [31:0] e_mwd;
      logic        e_cack;
      logic [31:0] e_crd;
      logic        e_dack;
      logic [31:0] e_drd;
      logic [1:0]  e_own;
   } vec_t;

   function automatic vec_t mk(
      logic rst, logic creq, logic cwe, logic [7:0] caddr, logic [31:0] cwd,
      logic dreq, logic dwe, logic [7:0] daddr, logic [31:0] dwd, logic [31:0] mrd,
      logic e_men, logic e_mwe, logic [7:0] e_maddr, logic [31:0] e_mwd,
      logic e_cack, logic [31:0] e_crd, logic e_dack, logic [31:0] e_drd, logic [1:0] e_own);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
      v.e_men = e_men; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
      v.e_cack = e_cack; v.e_crd = e_crd; v.e_dack = e_dack; v.e_drd = e_drd;
      v.e_own = e_own;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_ack && dma_ack) mutex_viol++;
   endtask

   vec_t vecs[$];
   logic [1:0] grants[$];
   logic [1:0] prev_own;
   int dack_cnt, men_cnt, cack_cnt;
   logic [1:0] first_grant;

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      mem_rdata = '0;

      //               rst cr cw ca     cwd           dr dw da     dwd           mrd
      //               men mwe maddr  mwd           cack crd          dack drd          own
      vecs.push_back(mk(1, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        0,0,8'h00,32'h0,         0,32'h0,       0,32'h0,       2'b00));
      vecs.push_back(mk(0, 1,1,8'h01,32'hDEADBEEF,  0,0,8'h00,32'h0,         32'h0,
                        1,1,8'h01,32'hDEADBEEF,  0,32'h0,       0,32'h0,       2'b01));
      vecs.push_back(mk(0, 1,1,8'h01,32'hDEADBEEF,  0,0,8'h00,32'h0,         32'h0,
                        0,1,8'h01,32'hDEADBEEF,  1,32'h0,       0,32'h0,       2'b01));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        0,1,8'h01,32'hDEADBEEF,  0,32'h0,       0,32'h0,       2'b00));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        0,1,8'h01,32'hDEADBEEF,  0,32'h0,       0,32'h0,       2'b00));
      vecs.push_back(mk(0, 1,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        1,0,8'h00,32'h0,         0,32'h0,       0,32'h0,       2'b01));
      vecs.push_back(mk(0, 1,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h12345678,
                        0,0,8'h00,32'h0,         1,32'h12345678,0,32'h0,       2'b01));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h12345678,
                        0,0,8'h00,32'h0,         0,32'h12345678,0,32'h0,       2'b00));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         1,0,8'h40,32'h0,         32'h0,
                        1,0,8'h40,32'h0,         0,32'h12345678,0,32'h0,       2'b10));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         1,0,8'h40,32'h0,         32'hCAFEF00D,
                        0,0,8'h40,32'h0,         0,32'h12345678,1,32'hCAFEF00D,2'b10));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        0,0,8'h40,32'h0,         0,32'h12345678,0,32'hCAFEF00D,2'b00));
      // Collision: CPU first, DMA granted as soon as the bus returns to IDLE.
      vecs.push_back(mk(0, 1,1,8'h10,32'h11111111,  1,1,8'h20,32'h22222222,  32'h0,
                        1,1,8'h10,32'h11111111,  0,32'h12345678,0,32'hCAFEF00D,2'b01));
      vecs.push_back(mk(0, 1,1,8'h10,32'h11111111,  1,1,8'h20,32'h22222222,  32'hAAAA5555,
                        0,1,8'h10,32'h11111111,  1,32'h12345678,0,32'hCAFEF00D,2'b01));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         1,1,8'h20,32'h22222222,  32'h0,
                        0,1,8'h10,32'h11111111,  0,32'h12345678,0,32'hCAFEF00D,2'b00));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         1,1,8'h20,32'h22222222,  32'h0,
                        1,1,8'h20,32'h22222222,  0,32'h12345678,0,32'hCAFEF00D,2'b10));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         1,1,8'h20,32'h22222222,  32'hFFFFFFFF,
                        0,1,8'h20,32'h22222222,  0,32'h12345678,1,32'hCAFEF00D,2'b10));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,         0,0,8'h00,32'h0,         32'h0,
                        0,1,8'h20,32'h22222222,  0,32'h12345678,0,32'hCAFEF00D,2'b00));

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
         cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
         dma_req = vecs[i].dreq; dma_we = vecs[i].dwe;
         dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwd;
         mem_rdata = vecs[i].mrd;
         tick();
         check($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(vecs[i].e_men));
         check($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].e_mwe));
         check($sformatf("v%0d.mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
         check($sformatf("v%0d.mem_wdata", i), mem_wdata,      vecs[i].e_mwd);
         check($sformatf("v%0d.cpu_ack", i),   32'(cpu_ack),   32'(vecs[i].e_cack));
         check($sformatf("v%0d.cpu_rdata", i), cpu_rdata,      vecs[i].e_crd);
         check($sformatf("v%0d.dma_ack", i),   32'(dma_ack),   32'(vecs[i].e_dack));
         check($sformatf("v%0d.dma_rdata", i), dma_rdata,      vecs[i].e_drd);
         check($sformatf("v%0d.bus_owner", i), 32'(bus_owner), 32'(vecs[i].e_own));
      end

      // Starvation: both held high; last DMA win above left the counter at 0.
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
      dma_req = 1; dma_we = 0; dma_addr = 8'h31;
      mem_rdata = 32'h5A5A0000;
      prev_own = bus_owner;
      for (int c = 0; c < 60 && grants.size() < 14; c++) begin
         tick();
         if (bus_owner != 2'b00 && prev_own == 2'b00) grants.push_back(bus_owner);
         prev_own = bus_owner;
      end
      check("starve.grant_count", 32'(grants.size()), 32'd14);
      foreach (grants[i])
         check($sformatf("starve.grant%0d", i), 32'(grants[i]),
               ((i % 5) == 4) ? 32'd2 : 32'd1);

      // Reset during a CPU ACCESS with starve_cnt at the limit: aborted, counter cleared.
      reset = 1;
      tick();
      check("rst_cpu.mem_en", 32'(mem_en), 32'd0);
      check("rst_cpu.bus_owner", 32'(bus_owner), 32'd0);
      check("rst_cpu.cpu_ack", 32'(cpu_ack), 32'd0);
      reset = 0;
      first_grant = 2'b00;
      dack_cnt = 0;
      prev_own = bus_owner;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (dma_ack) dack_cnt++;
         if (first_grant == 2'b00 && bus_owner != 2'b00 && prev_own == 2'b00)
            first_grant = bus_owner;
         prev_own = bus_owner;
      end
      check("rst_cpu.first_grant_after", 32'(first_grant), 32'd1);
      check("rst_cpu.no_dma_ack", 32'(dack_cnt), 32'd0);

      // Reset during a DMA read ACCESS: no dma_ack is ever issued for it.
      cpu_req = 0; dma_req = 0; reset = 1;
      tick();
      reset = 0;
      dma_req = 1; dma_we = 0; dma_addr = 8'h77; mem_rdata = 32'h0F0F0F0F;
      tick();
      check("rst_dma.owner_access", 32'(bus_owner), 32'd2);
      check("rst_dma.mem_en_access", 32'(mem_en), 32'd1);
      reset = 1;
      tick();
      check("rst_dma.mem_en", 32'(mem_en), 32'd0);
      check("rst_dma.bus_owner", 32'(bus_owner), 32'd0);
      check("rst_dma.dma_rdata", dma_rdata, 32'd0);
      reset = 0; dma_req = 0;
      dack_cnt = 0;
      men_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (dma_ack) dack_cnt++;
         if (mem_en) men_cnt++;
      end
      check("rst_dma.no_dma_ack", 32'(dack_cnt), 32'd0);
      check("rst_dma.no_mem_en", 32'(men_cnt), 32'd0);

      // Withdrawn request: CPU drops req during ACCESS; the access still completes once.
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05; mem_rdata = 32'h0BADF00D;
      tick();
      check("wd.owner_access", 32'(bus_owner), 32'd1);
      check("wd.mem_en_access", 32'(mem_en), 32'd1);
      cpu_req = 0;
      tick();
      check("wd.cpu_ack", 32'(cpu_ack), 32'd1);
      check("wd.cpu_rdata", cpu_rdata, 32'h0BADF00D);
      tick();
      check("wd.cpu_ack_drop", 32'(cpu_ack), 32'd0);
      check("wd.owner_idle", 32'(bus_owner), 32'd0);
      cack_cnt = 0;
      men_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (cpu_ack) cack_cnt++;
         if (mem_en) men_cnt++;
      end
      check("wd.no_second_ack", 32'(cack_cnt), 32'd0);
      check("wd.no_second_access", 32'(men_cnt), 32'd0);

      check("ack_mutex_violations", 32'(mutex_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
